// File: rtl/shared_bus_pkg.sv
// Shared types for the L2 snooping bus controller: snoop/opcode encodings,
// FSM states and snoop-response resolution.
package shared_bus_pkg;

    typedef enum logic [1:0] {
        SNOOP_NOHIT = 2'b00,
        SNOOP_HIT   = 2'b01,
        SNOOP_HITM  = 2'b10,
        SNOOP_RSVD  = 2'b11
    } snoop_t;

    typedef enum logic [7:0] {
        OP_IDLE       = 8'h00,
        OP_READ       = 8'h01,
        OP_WRITE      = 8'h02,
        OP_RWIM       = 8'h03,
        OP_INVALIDATE = 8'h04
    } bus_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_SNOOP,
        ST_RESP
    } bus_state_t;

    // The reserved code is treated as the most conservative response.
    function automatic snoop_t resolve_snoop(input logic [1:0] raw);
        return (raw == SNOOP_RSVD) ? SNOOP_HITM : snoop_t'(raw);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after rr_ptr_i,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr_i,
    output logic [$clog2(NUM_REQ)-1:0] winner_o,
    output logic                       any_valid_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] cand [NUM_REQ];

    // cand[gi] is the requester index sitting gi places after the pointer.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [IDX_W:0] sum;
        assign sum = {1'b0, rr_ptr_i} + (IDX_W+1)'(gi);
        assign cand[gi] = (sum >= (IDX_W+1)'(NUM_REQ))
                          ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                          : sum[IDX_W-1:0];
    end

    // Scan from the farthest candidate down so the nearest one wins.
    always_comb begin
        winner_o    = '0;
        any_valid_o = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_i[cand[k]]) begin
                winner_o    = cand[k];
                any_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_bus_controller.sv
// Round-robin sequencer for the shared snooping bus: grants one requester,
// drives its op/address for the snoop window and returns the snoop result.
module shared_bus_controller
    import shared_bus_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int LINE_SIZE  = 512,
    parameter int ADDR_W     = 32,
    parameter int SNOOP_WAIT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [8*NUM_REQ-1:0]      req_op,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic [1:0]                snoop_result,
    output logic [LINE_SIZE-1:0]      bus_data,
    output logic [7:0]                bus_op,
    output logic                      bus_drive,
    input  logic [1:0]                snoop_in
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(SNOOP_WAIT + 1);

    bus_state_t        state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  winner_q, winner_d;
    logic [7:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    snoop_t            snoop_q, snoop_d;

    logic [IDX_W-1:0]  arb_winner;
    logic              arb_any;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i       (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .winner_o    (arb_winner),
        .any_valid_o (arb_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
            winner_q <= '0;
            op_q     <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            snoop_q  <= SNOOP_NOHIT;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            winner_q <= winner_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            snoop_q  <= snoop_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        winner_d = winner_q;
        op_d     = op_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        snoop_d  = snoop_q;

        unique case (state_q)
            ST_IDLE: begin
                // Requester fields are frozen here; later req_* changes are ignored.
                if (arb_any) begin
                    state_d  = ST_ADDR;
                    winner_d = arb_winner;
                    op_d     = req_op[8*arb_winner +: 8];
                    addr_d   = req_addr[ADDR_W*arb_winner +: ADDR_W];
                    rr_ptr_d = (arb_winner == IDX_W'(NUM_REQ - 1)) ? '0 : arb_winner + 1'b1;
                end
            end
            ST_ADDR: begin
                state_d = ST_SNOOP;
                cnt_d   = '0;
            end
            ST_SNOOP: begin
                if (cnt_q == CNT_W'(SNOOP_WAIT - 1)) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                    snoop_d = resolve_snoop(snoop_in);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    logic [NUM_REQ-1:0] owner_onehot;
    assign owner_onehot = NUM_REQ'(1) << winner_q;

    always_comb begin
        grant     = '0;
        done      = '0;
        bus_drive = 1'b0;
        bus_data  = '0;
        bus_op    = '0;
        if (state_q != ST_IDLE) begin
            grant = owner_onehot;
        end
        if (state_q == ST_RESP) begin
            done = owner_onehot;
        end
        if (state_q == ST_ADDR || state_q == ST_SNOOP) begin
            bus_drive = 1'b1;
            bus_data  = LINE_SIZE'(addr_q);
            bus_op    = op_q;
        end
    end

    assign snoop_result = snoop_q;

endmodule

// File: tb/tb_shared_bus_controller.sv
// Scoreboard bench for shared_bus_controller: stimulus queues the expected
// completion, a monitor checks each done pulse against it.
module tb_shared_bus_controller;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [31:0]  req_op = '0;
    logic [127:0] req_addr = '0;
    logic [3:0]   grant;
    logic [3:0]   done;
    logic [1:0]   snoop_result;
    logic [511:0] bus_data;
    logic [7:0]   bus_op;
    logic         bus_drive;
    logic [1:0]   snoop_in = 2'b00;

    shared_bus_controller #(
        .NUM_REQ(4), .LINE_SIZE(512), .ADDR_W(32), .SNOOP_WAIT(2)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .req_addr(req_addr), .grant(grant), .done(done),
        .snoop_result(snoop_result), .bus_data(bus_data), .bus_op(bus_op),
        .bus_drive(bus_drive), .snoop_in(snoop_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [7:0]  op;
        logic [31:0] addr;
        logic [1:0]  snp;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   rem[4];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] op, input logic [31:0] addr);
        req_op[8*i +: 8]    = op;
        req_addr[32*i +: 32] = addr;
    endtask

    task automatic push_exp(input int idx, input logic [7:0] op, input logic [31:0] addr,
                            input logic [1:0] snp);
        exp_t e;
        e.idx = idx; e.op = op; e.addr = addr; e.snp = snp;
        exp_q.push_back(e);
    endtask

    // Each requester drops its request after its remaining count of dones.
    task automatic wait_dones(input int n);
        int got = 0;
        int budget = 200;
        while (got < n && budget > 0) begin
            @(negedge clk);
            budget--;
            if (done != 0) begin
                got++;
                for (int i = 0; i < 4; i++) begin
                    if (done[i]) begin
                        rem[i]--;
                        if (rem[i] <= 0) req_valid[i] = 1'b0;
                    end
                end
            end
        end
        if (got < n) begin
            total++; bad++;
            $display("FAIL done_timeout: got %0d dones required %0d", got, n);
        end
    endtask

    // Monitor: capture bus contents while driven, check on each done pulse.
    logic [511:0] cap_data;
    logic [7:0]   cap_op;
    initial begin
        exp_t e;
        logic [3:0] oh;
        cap_data = '0;
        cap_op   = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus_drive) begin
                    cap_data = bus_data;
                    cap_op   = bus_op;
                end
                if (done != 0) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_done: got done=%b required none", done);
                    end else begin
                        e  = exp_q.pop_front();
                        oh = 4'b0001 << e.idx;
                        $display("txn req=%0d op=%02h addr=%08h snoop=%b", e.idx, cap_op,
                                 cap_data[31:0], snoop_result);
                        chk("done_onehot", done, oh);
                        chk("grant_at_done", grant, oh);
                        chk("snoop_result", snoop_result, e.snp);
                        chk("bus_data", cap_data, {480'b0, e.addr});
                        chk("bus_op", cap_op, e.op);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) rem[i] = 0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_bus_drive", bus_drive, 0);
        chk("rst_bus_data", bus_data, 0);
        chk("rst_bus_op", bus_op, 0);
        chk("rst_snoop_result", snoop_result, 0);
        rst = 1'b0;
        @(negedge clk);

        // Contention 0101 from rr_ptr 0, then all four from rr_ptr 3
        snoop_in = 2'b01;
        set_req(0, 8'h01, 32'h0000_0100);
        set_req(1, 8'h02, 32'h0000_0200);
        set_req(2, 8'h03, 32'h0000_0300);
        set_req(3, 8'h04, 32'h0000_0400);
        push_exp(0, 8'h01, 32'h0000_0100, 2'b01);
        push_exp(2, 8'h03, 32'h0000_0300, 2'b01);
        push_exp(0, 8'h01, 32'h0000_0100, 2'b01);
        push_exp(2, 8'h03, 32'h0000_0300, 2'b01);
        rem[0] = 2; rem[2] = 2;
        req_valid = 4'b0101;
        wait_dones(4);
        push_exp(3, 8'h04, 32'h0000_0400, 2'b01);
        push_exp(0, 8'h01, 32'h0000_0100, 2'b01);
        push_exp(1, 8'h02, 32'h0000_0200, 2'b01);
        push_exp(2, 8'h03, 32'h0000_0300, 2'b01);
        rem[0] = 1; rem[1] = 1; rem[2] = 1; rem[3] = 1;
        req_valid = 4'b1111;
        wait_dones(4);

        // Single request with cycle-exact latency
        @(negedge clk);
        snoop_in = 2'b01;
        set_req(0, 8'h01, 32'h0000_0012);
        push_exp(0, 8'h01, 32'h0000_0012, 2'b01);
        req_valid = 4'b0001;
        @(negedge clk);
        chk("single_grant", grant, 4'b0001);
        chk("single_bus_drive", bus_drive, 1'b1);
        chk("single_bus_data", bus_data, 512'h12);
        chk("single_bus_op", bus_op, 8'h01);
        @(negedge clk);
        chk("single_done_early1", done, 0);
        @(negedge clk);
        chk("single_done_early2", done, 0);
        @(negedge clk);
        chk("single_done", done, 4'b0001);
        chk("single_resp_bus_drive", bus_drive, 1'b0);
        req_valid = 4'b0000;

        // Snoop resolution
        snoop_in = 2'b10;
        set_req(2, 8'h03, 32'h0000_0104);
        push_exp(2, 8'h03, 32'h0000_0104, 2'b10);
        rem[2] = 1; req_valid = 4'b0100;
        wait_dones(1);
        snoop_in = 2'b11;
        set_req(1, 8'h01, 32'h0000_0A04);
        push_exp(1, 8'h01, 32'h0000_0A04, 2'b10);
        rem[1] = 1; req_valid = 4'b0010;
        wait_dones(1);
        snoop_in = 2'b00;
        set_req(3, 8'h04, 32'h0000_0331);
        push_exp(3, 8'h04, 32'h0000_0331, 2'b00);
        rem[3] = 1; req_valid = 4'b1000;
        wait_dones(1);

        // Request withdrawn during SNOOP still completes
        @(negedge clk);
        snoop_in = 2'b01;
        set_req(1, 8'h02, 32'hBEEF_0040);
        push_exp(1, 8'h02, 32'hBEEF_0040, 2'b01);
        rem[1] = 1; req_valid = 4'b0010;
        @(negedge clk);
        chk("wd_grant_addr", grant, 4'b0010);
        @(negedge clk);
        req_valid = 4'b0000;
        wait_dones(1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("wd_no_regrant", grant, 0);
        end

        // Reset during the second SNOOP cycle
        snoop_in = 2'b10;
        set_req(1, 8'h01, 32'h0000_0777);
        req_valid = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_bus_drive", bus_drive, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_grant", grant, 0);
        chk("midrst_bus_drive", bus_drive, 0);
        chk("midrst_done", done, 0);
        chk("midrst_snoop_result", snoop_result, 0);
        req_valid = 4'b0000;
        @(negedge clk);
        chk("midrst_done_hold", done, 0);
        rst = 1'b0;
        snoop_in = 2'b01;
        set_req(0, 8'h01, 32'h0000_0055);
        set_req(3, 8'h02, 32'h0000_0077);
        push_exp(0, 8'h01, 32'h0000_0055, 2'b01);
        push_exp(3, 8'h02, 32'h0000_0077, 2'b01);
        rem[0] = 1; rem[3] = 1;
        req_valid = 4'b1001;
        wait_dones(2);

        // Idle
        @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("idle_grant", grant, 0);
            chk("idle_bus_drive", bus_drive, 0);
            chk("idle_bus_data", bus_data, 0);
            chk("idle_bus_op", bus_op, 0);
        end

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout required finish");
        $fatal(1, "timeout");
    end

endmodule
